// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/binary_to_common_anode_7segment.sv
// Existing 4-bit hex to common-anode 7-segment decoder, active-low {g,f,e,d,c,b,a}.
module Binary_To_Common_Anode_7Segment (
    input  logic [3:0] binary,
    output logic [6:0] segments_n
);

    always_comb begin
        segments_n = 7'b1000000;
        case (binary)
            4'h0: segments_n = 7'b1000000;
            4'h1: segments_n = 7'b1111001;
            4'h2: segments_n = 7'b0100100;
            4'h3: segments_n = 7'b0110000;
            4'h4: segments_n = 7'b0011001;
            4'h5: segments_n = 7'b0010010;
            4'h6: segments_n = 7'b0000010;
            4'h7: segments_n = 7'b1111000;
            4'h8: segments_n = 7'b0000000;
            4'h9: segments_n = 7'b0010000;
            4'hA: segments_n = 7'b0001000;
            4'hB: segments_n = 7'b0000011;
            4'hC: segments_n = 7'b1000110;
            4'hD: segments_n = 7'b0100001;
            4'hE: segments_n = 7'b0000110;
            4'hF: segments_n = 7'b0001110;
            default: segments_n = 7'b1000000;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Multiplexes NUM_DIGITS common-anode digits with a blanking gap and tear-free frame commits.
// state | meaning
// OFF   | display dark, waiting for enable
// DRIVE | current digit lit for REFRESH_DIV-BLANK_CYCLES cycles
// GAP   | all anodes off for BLANK_CYCLES cycles, then advance digit
module seven_segment_scan_controller
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic [6:0]              segments_n,
    output logic                    frame_tick
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - BLANK_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(BLANK_CYCLES - 1);

    scan_state_t             state;
    logic [IW-1:0]           idx;
    logic [CW-1:0]           cnt;
    logic [4*NUM_DIGITS-1:0] display;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pending_full;
    logic                    commit_q;
    logic                    wrap_edge;
    logic                    drive_on;
    logic [3:0]              nibble;
    logic [6:0]              seg_dec;
    logic [NUM_DIGITS-1:0]   anode_next;

    assign wrap_edge  = enable && (state == GAP) && (cnt == GAP_LAST) && (idx == IDX_LAST);
    assign drive_on   = enable && (state == DRIVE) && !blank_mask[idx];
    assign nibble     = display[{idx, 2'b00} +: 4];
    assign load_ready = !pending_full;

    Binary_To_Common_Anode_7Segment u_decoder (
        .binary     (nibble),
        .segments_n (seg_dec)
    );

    always_comb begin
        anode_next = '1;
        if (drive_on) anode_next[idx] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= OFF;
            idx   <= '0;
            cnt   <= '0;
        end else if (!enable) begin
            state <= OFF;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                OFF: begin
                    state <= DRIVE;
                    cnt   <= '0;
                end
                DRIVE: begin
                    if (cnt == DRIVE_LAST) begin
                        state <= GAP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= DRIVE;
                        cnt   <= '0;
                        idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= OFF;
                    idx   <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // commit_q holds ready low for one extra cycle so it reopens the cycle after the commit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending      <= '0;
            display      <= '0;
            pending_full <= 1'b0;
            commit_q     <= 1'b0;
        end else begin
            if (load_valid && !pending_full) begin
                pending      <= load_data;
                pending_full <= 1'b1;
            end
            if (commit_q) begin
                pending_full <= 1'b0;
                commit_q     <= 1'b0;
            end else if (pending_full && (wrap_edge || state == OFF)) begin
                display  <= pending;
                commit_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            anode_n    <= '1;
            segments_n <= SEG_BLANK;
            frame_tick <= 1'b0;
        end else begin
            anode_n    <= anode_next;
            segments_n <= drive_on ? seg_dec : SEG_BLANK;
            frame_tick <= wrap_edge;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench for the scan controller with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seven_segment_scan_controller;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  blank_mask;
    logic [3:0]  anode_n;
    logic [6:0]  segments_n;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    seven_segment_scan_controller #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .blank_mask (blank_mask),
        .anode_n    (anode_n),
        .segments_n (segments_n),
        .frame_tick (frame_tick)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_frame_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clock);
            if (frame_tick === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset_n    = 1'b0;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        blank_mask = 4'b0000;
        step(3);
        total++; if (anode_n !== 4'hF) begin bad++; $display("FAIL reset_anode got=%h want=f", anode_n); end
        total++; if (segments_n !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h want=7f", segments_n); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", load_ready); end
        total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", frame_tick); end
    endtask

    task automatic test_scan;
        logic [3:0] ea;
        logic [6:0] es;
        logic       et;
        int         p, d;
        reset_n = 1'b1;
        enable  = 1'b1;
        for (int c = 1; c <= 65; c++) begin
            @(negedge clock);
            ea = 4'hF;
            es = 7'h7F;
            if (c >= 2) begin
                p = (c - 2) % 8;
                d = ((c - 2) / 8) % 4;
                if (p < 6) begin
                    ea = an_of(d);
                    es = 7'b1000000;
                end
            end
            et = (c == 33) || (c == 65);
            total++; if (anode_n !== ea) begin bad++; $display("FAIL scan_anode c=%0d got=%b want=%b", c, anode_n, ea); end
            total++; if (segments_n !== es) begin bad++; $display("FAIL scan_seg c=%0d got=%b want=%b", c, segments_n, es); end
            total++; if (frame_tick !== et) begin bad++; $display("FAIL scan_tick c=%0d got=%b want=%b", c, frame_tick, et); end
        end
    endtask

    task automatic test_load;
        bit         ok;
        logic [3:0] nib [4];
        nib[0] = 4'h0; nib[1] = 4'hF; nib[2] = 4'h3; nib[3] = 4'hA;
        wait_frame_tick(ok);
        total++; if (!ok) begin bad++; $display("FAIL load_tick_timeout got=none want=pulse"); end
        step(10);
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL load_ready_before got=%b want=1", load_ready); end
        load_valid = 1'b1;
        load_data  = 16'hA3F0;
        step(1);
        load_valid = 1'b0;
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL load_ready_after got=%b want=0", load_ready); end
        step(6);
        total++; if (anode_n !== 4'b1011) begin bad++; $display("FAIL load_old_d2_anode got=%b want=1011", anode_n); end
        total++; if (segments_n !== 7'b1000000) begin bad++; $display("FAIL load_old_d2_seg got=%b want=1000000", segments_n); end
        step(8);
        total++; if (segments_n !== 7'b1000000) begin bad++; $display("FAIL load_old_d3_seg got=%b want=1000000", segments_n); end
        wait_frame_tick(ok);
        total++; if (!ok) begin bad++; $display("FAIL load_commit_timeout got=none want=pulse"); end
        for (int d = 0; d < 4; d++) begin
            step(d == 0 ? 1 : 8);
            total++; if (anode_n !== an_of(d)) begin bad++; $display("FAIL load_d%0d_anode got=%b want=%b", d, anode_n, an_of(d)); end
            total++; if (segments_n !== seg_of(nib[d])) begin bad++; $display("FAIL load_d%0d_seg got=%b want=%b", d, segments_n, seg_of(nib[d])); end
        end
    endtask

    task automatic test_ignore;
        bit         ok;
        logic [3:0] nib [4];
        nib[0] = 4'hE; nib[1] = 4'h2; nib[2] = 4'hB; nib[3] = 4'h9;
        wait_frame_tick(ok);
        total++; if (!ok) begin bad++; $display("FAIL ign_tick_timeout got=none want=pulse"); end
        step(3);
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL ign_ready_first got=%b want=1", load_ready); end
        load_valid = 1'b1;
        load_data  = 16'h9B2E;
        step(1);
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL ign_ready_busy got=%b want=0", load_ready); end
        load_data = 16'h1111;
        step(6);
        load_valid = 1'b0;
        wait_frame_tick(ok);
        total++; if (!ok) begin bad++; $display("FAIL ign_commit_timeout got=none want=pulse"); end
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL ign_ready_at_tick got=%b want=0", load_ready); end
        step(1);
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL ign_ready_after_tick got=%b want=1", load_ready); end
        for (int d = 0; d < 4; d++) begin
            if (d > 0) step(8);
            total++; if (anode_n !== an_of(d)) begin bad++; $display("FAIL ign_d%0d_anode got=%b want=%b", d, anode_n, an_of(d)); end
            total++; if (segments_n !== seg_of(nib[d])) begin bad++; $display("FAIL ign_d%0d_seg got=%b want=%b", d, segments_n, seg_of(nib[d])); end
        end
    endtask

    task automatic test_blank_mask;
        bit         ok;
        logic [3:0] ea [4];
        logic [6:0] es [4];
        ea[0] = 4'b1110; es[0] = 7'b0000110;
        ea[1] = 4'b1111; es[1] = 7'h7F;
        ea[2] = 4'b1011; es[2] = 7'b0000011;
        ea[3] = 4'b0111; es[3] = 7'b0010000;
        wait_frame_tick(ok);
        total++; if (!ok) begin bad++; $display("FAIL mask_tick_timeout got=none want=pulse"); end
        blank_mask = 4'b0010;
        for (int d = 0; d < 4; d++) begin
            step(d == 0 ? 1 : 8);
            total++; if (anode_n !== ea[d]) begin bad++; $display("FAIL mask_d%0d_anode got=%b want=%b", d, anode_n, ea[d]); end
            total++; if (segments_n !== es[d]) begin bad++; $display("FAIL mask_d%0d_seg got=%b want=%b", d, segments_n, es[d]); end
        end
        step(1);
        blank_mask = 4'b0000;
    endtask

    task automatic test_disable;
        bit ok;
        wait_frame_tick(ok);
        total++; if (!ok) begin bad++; $display("FAIL dis_tick_timeout got=none want=pulse"); end
        step(18);
        total++; if (anode_n !== 4'b1011) begin bad++; $display("FAIL dis_d2_before got=%b want=1011", anode_n); end
        enable = 1'b0;
        step(1);
        total++; if (anode_n !== 4'hF) begin bad++; $display("FAIL dis_anode_off got=%b want=1111", anode_n); end
        total++; if (segments_n !== 7'h7F) begin bad++; $display("FAIL dis_seg_off got=%b want=1111111", segments_n); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL dis_ready_idle got=%b want=1", load_ready); end
        load_valid = 1'b1;
        load_data  = 16'h0001;
        step(1);
        load_valid = 1'b0;
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL dis_ready_taken got=%b want=0", load_ready); end
        ok = 1'b0;
        for (int i = 0; i < 4 && !ok; i++) begin
            step(1);
            if (load_ready === 1'b1) ok = 1'b1;
        end
        total++; if (!ok) begin bad++; $display("FAIL dis_ready_return got=%b want=1", load_ready); end
        total++; if (anode_n !== 4'hF) begin bad++; $display("FAIL dis_anode_dark got=%b want=1111", anode_n); end
        enable = 1'b1;
        step(2);
        total++; if (anode_n !== 4'b1110) begin bad++; $display("FAIL dis_restart_anode got=%b want=1110", anode_n); end
        total++; if (segments_n !== 7'b1111001) begin bad++; $display("FAIL dis_restart_seg got=%b want=1111001", segments_n); end
        step(8);
        total++; if (anode_n !== 4'b1101) begin bad++; $display("FAIL dis_d1_anode got=%b want=1101", anode_n); end
        total++; if (segments_n !== 7'b1000000) begin bad++; $display("FAIL dis_d1_seg got=%b want=1000000", segments_n); end
    endtask

    task automatic test_async_reset;
        bit ok;
        wait_frame_tick(ok);
        total++; if (!ok) begin bad++; $display("FAIL ar_tick_timeout got=none want=pulse"); end
        step(2);
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
        step(1);
        load_valid = 1'b0;
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL ar_ready_pending got=%b want=0", load_ready); end
        total++; if (anode_n !== 4'b1110) begin bad++; $display("FAIL ar_anode_before got=%b want=1110", anode_n); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (anode_n !== 4'hF) begin bad++; $display("FAIL ar_anode_async got=%b want=1111", anode_n); end
        total++; if (segments_n !== 7'h7F) begin bad++; $display("FAIL ar_seg_async got=%b want=1111111", segments_n); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL ar_ready_async got=%b want=1", load_ready); end
        total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL ar_tick_async got=%b want=0", frame_tick); end
        #1 reset_n = 1'b1;
        wait_frame_tick(ok);
        total++; if (!ok) begin bad++; $display("FAIL ar_restart_timeout got=none want=pulse"); end
        for (int d = 0; d < 4; d++) begin
            step(d == 0 ? 1 : 8);
            total++; if (anode_n !== an_of(d)) begin bad++; $display("FAIL ar_d%0d_anode got=%b want=%b", d, anode_n, an_of(d)); end
            total++; if (segments_n !== 7'b1000000) begin bad++; $display("FAIL ar_d%0d_seg got=%b want=1000000", d, segments_n); end
        end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL ar_ready_after got=%b want=1", load_ready); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_ignore();
        test_blank_mask();
        test_disable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
